// File: rtl/port_arbiter.sv
// Write-path arbiter for the switch ingress ports: picks a port by priority with
// round-robin tie-break, holds the grant for one packet, ends it on length or watchdog.
module port_arbiter #(
  parameter int PORT_NUM = 16,
  parameter int LEN_W    = 9,
  parameter int TIMEOUT  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PORT_NUM-1:0]       req,
  input  logic [PORT_NUM*4-1:0]     req_dest,
  input  logic [PORT_NUM*3-1:0]     req_prior,
  input  logic [PORT_NUM*LEN_W-1:0] req_length,
  input  logic [PORT_NUM-1:0]       beat_vld,
  output logic                      grant_vld,
  output logic [PORT_NUM-1:0]       grant_onehot,
  output logic [3:0]                grant_port,
  output logic [3:0]                grant_dest,
  output logic [2:0]                grant_prior,
  output logic [LEN_W-1:0]          beat_cnt,
  output logic [PORT_NUM-1:0]       xfer_stop,
  output logic                      pkt_done,
  output logic                      timeout_err
);

  localparam int IDX_W = $clog2(PORT_NUM);
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {IDLE, XFER, DONE, ABORT} state_t;

  state_t              state_q, state_d;
  logic                grant_vld_q, grant_vld_d;
  logic [PORT_NUM-1:0] grant_onehot_q, grant_onehot_d;
  logic [IDX_W-1:0]    grant_port_q, grant_port_d;
  logic [3:0]          grant_dest_q, grant_dest_d;
  logic [2:0]          grant_prior_q, grant_prior_d;
  logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0]    target_q, target_d;
  logic [PORT_NUM-1:0] xfer_stop_q, xfer_stop_d;
  logic                pkt_done_q, pkt_done_d;
  logic                timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]    idle_q, idle_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic                found_s;
  logic [IDX_W-1:0]    win_s;
  logic [2:0]          best_s;
  logic [3:0]          win_dest_s;
  logic [LEN_W-1:0]    win_len_s;
  logic [LEN_W-1:0]    target_len_s;
  logic                beat_s;
  logic [LEN_W-1:0]    beat_inc_s;
  logic [CNT_W-1:0]    idle_inc_s;

  // Priority search in round-robin order; strict less-than keeps the first tie found.
  always_comb begin
    int idx;
    found_s = 1'b0;
    win_s   = {IDX_W{1'b0}};
    best_s  = 3'd7;
    idx     = 0;
    for (int k = 1; k <= PORT_NUM; k++) begin
      idx = (int'(rr_ptr_q) + k) % PORT_NUM;
      if (req[idx] && (!found_s || (req_prior[3*idx +: 3] < best_s))) begin
        found_s = 1'b1;
        best_s  = req_prior[3*idx +: 3];
        win_s   = IDX_W'(idx);
      end else begin
        found_s = found_s;
      end
    end
    win_dest_s   = req_dest[4*int'(win_s) +: 4];
    win_len_s    = req_length[LEN_W*int'(win_s) +: LEN_W];
    target_len_s = (win_len_s == {LEN_W{1'b0}}) ? LEN_W'(1) : win_len_s;
  end

  // Beat qualification, saturating beat counter and watchdog increment.
  always_comb begin
    beat_s     = |(beat_vld & grant_onehot_q);
    beat_inc_s = (beat_cnt_q == {LEN_W{1'b1}}) ? beat_cnt_q : beat_cnt_q + LEN_W'(1);
    idle_inc_s = idle_q + CNT_W'(1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    grant_vld_d    = grant_vld_q;
    grant_onehot_d = grant_onehot_q;
    grant_port_d   = grant_port_q;
    grant_dest_d   = grant_dest_q;
    grant_prior_d  = grant_prior_q;
    beat_cnt_d     = beat_cnt_q;
    target_d       = target_q;
    xfer_stop_d    = xfer_stop_q;
    pkt_done_d     = 1'b0;
    timeout_err_d  = 1'b0;
    idle_d         = idle_q;
    rr_ptr_d       = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d        = XFER;
          grant_vld_d    = 1'b1;
          grant_onehot_d = {{(PORT_NUM-1){1'b0}}, 1'b1} << win_s;
          grant_port_d   = win_s;
          grant_dest_d   = win_dest_s;
          grant_prior_d  = best_s;
          target_d       = target_len_s;
          beat_cnt_d     = {LEN_W{1'b0}};
          idle_d         = {CNT_W{1'b0}};
          rr_ptr_d       = win_s;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        // A final beat on the watchdog threshold cycle still completes the packet.
        if (beat_s) begin
          beat_cnt_d = beat_inc_s;
          idle_d     = {CNT_W{1'b0}};
          if (beat_inc_s == target_q) begin
            state_d     = DONE;
            xfer_stop_d = grant_onehot_q;
            pkt_done_d  = 1'b1;
          end else begin
            state_d = XFER;
          end
        end else if (idle_inc_s == CNT_W'(TIMEOUT)) begin
          state_d       = ABORT;
          idle_d        = idle_inc_s;
          xfer_stop_d   = grant_onehot_q;
          timeout_err_d = 1'b1;
        end else begin
          idle_d = idle_inc_s;
        end
      end
      DONE, ABORT: begin
        state_d        = IDLE;
        grant_vld_d    = 1'b0;
        grant_onehot_d = {PORT_NUM{1'b0}};
        xfer_stop_d    = {PORT_NUM{1'b0}};
        idle_d         = {CNT_W{1'b0}};
      end
      default: begin
        state_d        = IDLE;
        grant_vld_d    = 1'b0;
        grant_onehot_d = {PORT_NUM{1'b0}};
        xfer_stop_d    = {PORT_NUM{1'b0}};
      end
    endcase
  end

  // State and output registers; reset makes port 0 win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      grant_vld_q    <= 1'b0;
      grant_onehot_q <= {PORT_NUM{1'b0}};
      grant_port_q   <= {IDX_W{1'b0}};
      grant_dest_q   <= 4'd0;
      grant_prior_q  <= 3'd0;
      beat_cnt_q     <= {LEN_W{1'b0}};
      target_q       <= {LEN_W{1'b0}};
      xfer_stop_q    <= {PORT_NUM{1'b0}};
      pkt_done_q     <= 1'b0;
      timeout_err_q  <= 1'b0;
      idle_q         <= {CNT_W{1'b0}};
      rr_ptr_q       <= IDX_W'(PORT_NUM - 1);
    end else begin
      state_q        <= state_d;
      grant_vld_q    <= grant_vld_d;
      grant_onehot_q <= grant_onehot_d;
      grant_port_q   <= grant_port_d;
      grant_dest_q   <= grant_dest_d;
      grant_prior_q  <= grant_prior_d;
      beat_cnt_q     <= beat_cnt_d;
      target_q       <= target_d;
      xfer_stop_q    <= xfer_stop_d;
      pkt_done_q     <= pkt_done_d;
      timeout_err_q  <= timeout_err_d;
      idle_q         <= idle_d;
      rr_ptr_q       <= rr_ptr_d;
    end
  end

  assign grant_vld    = grant_vld_q;
  assign grant_onehot = grant_onehot_q;
  assign grant_port   = grant_port_q;
  assign grant_dest   = grant_dest_q;
  assign grant_prior  = grant_prior_q;
  assign beat_cnt     = beat_cnt_q;
  assign xfer_stop    = xfer_stop_q;
  assign pkt_done     = pkt_done_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: doc/port_arbiter.md
Name: port_arbiter

Overview:
- Shares the single switch write path between 16 ingress ports.
- Each port raises a request carrying the parsed control-frame fields (dest, priority, length).
- The arbiter picks one port by priority with round-robin tie-break, then holds the grant while that port streams its packet.
- It counts beats, issues a one-cycle xfer_stop to the granted port at packet end, and aborts stalled transfers by watchdog.

Parameters:
- PORT_NUM, 16, number of requesting ports; 4-bit port index.
- LEN_W, 9, width of the packet length field in 16-bit words.
- TIMEOUT, 32, consecutive idle cycles in XFER before abort; range 2..255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- req  input  16  per-port request; level, held until granted packet completes.
- req_dest  input  64  packed 4-bit dest per port; port i at [4i+3:4i].
- req_prior  input  48  packed 3-bit priority per port; port i at [3i+2:3i]; 0 = highest.
- req_length  input  144  packed 9-bit length per port; port i at [9i+8:9i].
- beat_vld  input  16  per-port data beat valid; only the granted port's bit is counted.
- grant_vld  output  1  a packet transfer is granted.
- grant_onehot  output  16  one-hot granted port.
- grant_port  output  4  granted port index.
- grant_dest  output  4  latched dest of granted packet.
- grant_prior  output  3  latched priority of granted packet.
- beat_cnt  output  9  beats accepted in current grant.
- xfer_stop  output  16  one-cycle one-hot stop pulse to the granted port.
- pkt_done  output  1  one-cycle pulse on normal completion.
- timeout_err  output  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (synchronous, active-high):
  - all outputs 0; state IDLE.
  - rr_ptr = 15, so port 0 wins the first tie.
  - idle counter 0.
  - Reset mid-XFER drops the grant immediately with no xfer_stop or pkt_done.
- IDLE, arbitration:
  - Candidate set = req bits.
  - Winner = candidate with lowest req_prior value.
  - Ties resolve round-robin: first candidate found scanning rr_ptr+1, rr_ptr+2, ... mod 16.
- IDLE -> XFER: next cycle after a non-empty candidate set.
  - Registers grant_vld=1, grant_onehot, grant_port, grant_dest, grant_prior.
  - Latches target = req_length of the winner; length 0 is treated as 1.
  - Sets beat_cnt=0 and rr_ptr=winner.
  - Arbitration latency: req rise to grant_vld = 1 cycle.
- XFER:
  - Each cycle with beat_vld[grant_port]=1 increments beat_cnt (saturates at 511).
  - beat_vld bits of non-granted ports are ignored.
  - The beat that makes beat_cnt == target moves the FSM to DONE.
- DONE, one cycle:
  - xfer_stop[grant_port]=1, pkt_done=1, grant_vld stays 1.
  - Next cycle: grant_vld, grant_onehot and xfer_stop clear; state IDLE.
  - grant_port, grant_dest and grant_prior hold their last value.
  - beat_cnt holds until the next grant.
- Packet gap: the minimum gap between consecutive grants is 1 IDLE cycle.
- Requests and watchdog:
  - req changes during XFER/DONE are ignored.
  - Deassertion of the granted port's req mid-XFER does not end the grant.
  - Watchdog: in XFER, the idle counter increments on cycles without a granted beat and clears on a beat.
  - When the idle counter reaches TIMEOUT, go to ABORT.
- ABORT, one cycle:
  - xfer_stop[grant_port]=1, timeout_err=1, pkt_done=0.
  - Then IDLE with identical clearing to DONE.
  - rr_ptr keeps the aborted port, so it goes last among equals.
- Simultaneous events:
  - The final beat arriving in the same cycle as the timeout threshold counts as a beat: DONE, not ABORT.
- Invariants:
  - xfer_stop and grant_onehot are never multi-hot.
  - xfer_stop is only ever set on the granted port.

Test Plan:
- Reset release, then req=0x0001 with prior 3 and length 4, beats back-to-back:
  - grant_vld rises 1 cycle after req; grant_port=0.
  - beat_cnt reaches 4; next cycle xfer_stop=0x0001 and pkt_done=1.
  - grant_vld=0 one cycle later.
- req=0x0104: port 2 prior 5, port 8 prior 1:
  - port 8 granted first; port 2 granted after 1 IDLE gap.
- Ports 1, 5, 9 all prior 0, each sending 1-beat packets, req held high throughout:
  - grant order 1, 5, 9, 1, ...
  - each grant has xfer_stop on the matching single bit.
- Port 3 granted with length 10, then no beats for TIMEOUT=32 cycles:
  - timeout_err and xfer_stop=0x0008 pulse 32 cycles after the grant cycle.
  - pkt_done=0; FSM back in IDLE.
- Port 4 granted with length 0, plus stray beat_vld on port 6:
  - one port-4 beat ends the packet; port-6 beats do not change beat_cnt.
- rst asserted at beat 3 of a 6-beat packet:
  - next cycle all outputs 0 with no xfer_stop.
  - after release, port 0 wins a tie against port 15.
